// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU; logic ops finish in one cycle, multiply is a WIDTH-cycle shift-add.
// Define ALU_MUL_EN to build the multiplier; without it opcode 7 completes in one cycle with err=1.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         select,
  output logic [2*WIDTH-1:0] out,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int W2 = 2 * WIDTH;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [2:0]       sel_reg;
  logic [WIDTH:0]   sum, diff;
  logic [W2-1:0]    exec_res;
  logic             exec_err;

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt;
  logic [W2-1:0] acc, acc_sum;
  logic          mul_last;

  // one multiplier bit per edge; the final partial product lands directly in out
  assign acc_sum  = acc + (b_reg[cnt] ? ({{WIDTH{1'b0}}, a_reg} << cnt) : {W2{1'b0}});
  assign mul_last = (cnt == CW'(WIDTH - 1));
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef ALU_MUL_EN
          state_nxt = (select == 3'd7) ? MUL : EXEC;
`else
          state_nxt = EXEC;
`endif
        end
      end
      EXEC: state_nxt = IDLE;
`ifdef ALU_MUL_EN
      MUL: if (mul_last) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sum      = {1'b0, a_reg} + {1'b0, b_reg};
    diff     = {1'b0, a_reg} - {1'b0, b_reg};
    exec_res = '0;
    exec_err = 1'b0;
    case (sel_reg)
      3'd0: exec_res = {{(WIDTH-1){1'b0}}, sum};
      3'd1: exec_res = {{(WIDTH-1){1'b0}}, diff};
      3'd2: exec_res = {{WIDTH{1'b0}}, a_reg & b_reg};
      3'd3: exec_res = {{WIDTH{1'b0}}, a_reg | b_reg};
      3'd4: exec_res = {{WIDTH{1'b0}}, a_reg ^ b_reg};
      3'd5: exec_res = {{(WIDTH-1){1'b0}}, a_reg, 1'b0};
      3'd6: exec_res = {{WIDTH{1'b0}}, a_reg >> 1};
      default: exec_err = 1'b1;  // multiply only reaches EXEC when it is compiled out
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      out     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sel_reg <= '0;
`ifdef ALU_MUL_EN
      acc     <= '0;
      cnt     <= '0;
`endif
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            sel_reg <= select;
            busy    <= 1'b1;
`ifdef ALU_MUL_EN
            acc     <= '0;
            cnt     <= '0;
`endif
          end
        end
        EXEC: begin
          out  <= exec_res;
          err  <= exec_err;
          done <= 1'b1;
          busy <= 1'b0;
        end
`ifdef ALU_MUL_EN
        MUL: begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
          if (mul_last) begin
            out  <= acc_sum;
            err  <= 1'b0;
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: cycle model of the handshake plus directed vectors with literal results.
module tb_alu_seq;
  localparam int W  = 4;
  localparam int W2 = 2 * W;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start;
  logic [W-1:0]  a, b;
  logic [2:0]    select;
  logic [W2-1:0] out;
  logic          busy, done, err;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .select(select),
    .out(out), .busy(busy), .done(done), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the spec says each op returns, and how many edges it takes.
  function automatic int unsigned ref_op(input int unsigned x, input int unsigned y, input int unsigned s);
    case (s)
      0: return x + y;
      1: return (x + (1 << (W + 1)) - y) % (1 << (W + 1));
      2: return x & y;
      3: return x | y;
      4: return x ^ y;
      5: return x * 2;
      6: return x / 2;
      default: return MUL_EN ? x * y : 0;
    endcase
  endfunction

  int            m_left = 0;
  logic [W2-1:0] m_out = '0, m_pend = '0;
  bit            m_busy = 0, m_done = 0, m_err = 0, m_perr = 0;
  bit            chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_out = '0; m_busy = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_out = m_pend; m_err = m_perr; m_done = 1; m_busy = 0;
        end
      end else if (start) begin
        m_pend = W2'(ref_op(a, b, select));
        m_perr = (select == 3'd7) && !MUL_EN;
        m_left = (select == 3'd7 && MUL_EN) ? W : 1;
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("out", out, m_out);
      check("err", err, m_err);
      check("busy_done_excl", busy & done, 0);
    end
  end

  task automatic wait_done(output bit got, output int cyc);
    got = 0; cyc = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1;
    end
  endtask

  task automatic run_op(input string name, input int av, input int bv, input int sv,
                        input int exp_out, input bit exp_err, input int exp_lat);
    bit got; int cyc;
    @(posedge clk); #1;
    a = W'(av); b = W'(bv); select = 3'(sv); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_busy_after_accept"}, busy, 1);
    wait_done(got, cyc);
    check({name, "_done_seen"}, got, 1);
    if (got) begin
      check({name, "_latency"}, cyc - 1, exp_lat);
      check({name, "_out"}, out, exp_out);
      check({name, "_err"}, err, exp_err);
    end
    @(negedge clk);
    check({name, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit got; int cyc; int cnt_done;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; select = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; chk_en = 1;
    @(negedge clk);
    check("reset_out", out, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);

    run_op("add_1_0", 1, 0, 0, 1, 0, 1);
    run_op("add_carry", 15, 15, 0, 30, 0, 1);
    run_op("sub_5_3", 5, 3, 1, 2, 0, 1);
    run_op("sub_3_5", 3, 5, 1, 30, 0, 1);
    run_op("xor_5_3", 5, 3, 4, 6, 0, 1);
    run_op("shl1_15", 15, 0, 5, 30, 0, 1);
    run_op("and_12_10", 12, 10, 2, 8, 0, 1);
    run_op("or_12_10", 12, 10, 3, 14, 0, 1);
    run_op("shr1_13", 13, 0, 6, 6, 0, 1);
`ifdef ALU_MUL_EN
    run_op("mul_15_15", 15, 15, 7, 225, 0, 4);
    run_op("mul_0_9", 0, 9, 7, 0, 0, 4);
`else
    run_op("op7_disabled", 15, 15, 7, 0, 1, 1);
`endif
    run_op("add_after_op7", 2, 3, 0, 5, 0, 1);

    // start held and operands churned while busy: result must reflect the captured pair
    @(posedge clk); #1;
    a = 4'd13; b = 4'd11; select = MUL_EN ? 3'd7 : 3'd0; start = 1'b1;
    @(posedge clk); #1;
    a = 4'd2; b = 4'd3; select = 3'd1;
    got = 0; cyc = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1;
      else begin a = W'(cyc); b = W'(cyc + 3); end
    end
    check("ignore_done_seen", got, 1);
    check("ignore_latency", cyc - 1, MUL_EN ? 4 : 1);
    check("ignore_out", out, MUL_EN ? 143 : 24);
    @(negedge clk);
    check("reaccept_after_idle", busy, 1);
    start = 1'b0;
    wait_done(got, cyc);
    check("reaccept_done_seen", got, 1);
    @(negedge clk);

    // reset in the middle of a multiply
    @(posedge clk); #1;
    a = 4'd15; b = 4'd15; select = 3'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out", out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    got = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) got = 1;
    end
    check("midrst_no_done", got, 0);
    run_op("add_7_9", 7, 9, 0, 16, 0, 1);

    // start held continuously: one single-cycle result every two cycles
    @(posedge clk); #1;
    a = 4'd12; b = 4'd10; select = 3'd3; start = 1'b1;
    cnt_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    start = 1'b0;
    check("held_start_throughput", cnt_done, 4);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
